// File: rtl/tcon_arbiter.sv
// tcon_arbiter: round-robin, burst-limited arbiter sharing the tcon 8-bit
// 2:1 select datapath between requesters A and B. The granted beat is
// captured into a single registered output stage, and each grant is capped
// at MAX_BURST accepted beats before the arbiter re-arbitrates.
module tcon_arbiter #(
  parameter int DATA_W    = 8,
  parameter int MAX_BURST = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              a_valid,
  input  logic [DATA_W-1:0] a_data,
  output logic              a_ready,
  input  logic              b_valid,
  input  logic [DATA_W-1:0] b_data,
  output logic              b_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  output logic              sel,
  output logic              busy
);

  localparam int CW = $clog2(MAX_BURST + 1);
  localparam logic [CW-1:0] LAST_BEAT = CW'(MAX_BURST - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_A = 2'd1,
    GNT_B = 2'd2
  } state_t;

  state_t            state_q;
  logic              rrA_q;
  logic [CW-1:0]     cnt_q;
  logic              out_valid_q;
  logic [DATA_W-1:0] out_data_q;

  logic loadEn;
  logic aFire;
  logic bFire;
  logic lastBeat;
  logic relA;
  logic relB;

  // Handshake decode: the output stage can take a beat when empty or draining,
  // and a grant ends when its owner goes quiet or its final allowed beat lands.
  always_comb begin
    loadEn   = ~out_valid_q | out_ready;
    a_ready  = (state_q == GNT_A) & loadEn;
    b_ready  = (state_q == GNT_B) & loadEn;
    aFire    = a_valid & a_ready;
    bFire    = b_valid & b_ready;
    lastBeat = (cnt_q == LAST_BEAT);
    relA     = (state_q == GNT_A) & (~a_valid | (aFire & lastBeat));
    relB     = (state_q == GNT_B) & (~b_valid | (bFire & lastBeat));
  end

  // Grant FSM plus output register; a release overrides the beat counter
  // increment so the next grant always starts counting from zero.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rrA_q       <= 1'b1;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      if (aFire) begin
        out_data_q  <= a_data;
        out_valid_q <= 1'b1;
        cnt_q       <= cnt_q + 1'b1;
      end else if (bFire) begin
        out_data_q  <= b_data;
        out_valid_q <= 1'b1;
        cnt_q       <= cnt_q + 1'b1;
      end else if (out_ready) begin
        out_valid_q <= 1'b0;
      end

      case (state_q)
        IDLE: begin
          if (a_valid && (!b_valid || rrA_q)) begin
            state_q <= GNT_A;
          end else if (b_valid) begin
            state_q <= GNT_B;
          end
        end
        GNT_A: begin
          if (relA) begin
            rrA_q <= 1'b0;
            cnt_q <= '0;
            if (b_valid) begin
              state_q <= GNT_B;
            end else if (a_valid) begin
              state_q <= GNT_A;
            end else begin
              state_q <= IDLE;
            end
          end
        end
        GNT_B: begin
          if (relB) begin
            rrA_q <= 1'b1;
            cnt_q <= '0;
            if (a_valid) begin
              state_q <= GNT_A;
            end else if (b_valid) begin
              state_q <= GNT_B;
            end else begin
              state_q <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign sel       = (state_q == GNT_A);
  assign busy      = (state_q != IDLE);
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

endmodule

// File: tb/tb_tcon_arbiter.sv
// tb_tcon_arbiter: directed bench for tcon_arbiter. Inputs change on the
// falling edge; outputs are compared shortly after, before the next rising edge.
module tb_tcon_arbiter;

  logic       clk;
  logic       rst_n;
  logic       a_valid;
  logic [7:0] a_data;
  logic       a_ready;
  logic       b_valid;
  logic [7:0] b_data;
  logic       b_ready;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_ready;
  logic       sel;
  logic       busy;

  int checks   = 0;
  int failures = 0;

  logic [7:0] aBase = 8'h00;
  logic [7:0] bBase = 8'h00;
  logic [7:0] aIdx  = 8'h00;
  logic [7:0] bIdx  = 8'h00;

  // Test 3 expectations: grant owner per cycle and the output beat stream.
  logic       t3Sel [14] = '{0, 0, 0, 0, 0, 1, 1, 1, 1, 0, 0, 0, 0, 1};
  logic [7:0] t3Out [12] = '{8'hB0, 8'hB1, 8'hB2, 8'hB3, 8'hA0, 8'hA1,
                             8'hA2, 8'hA3, 8'hB4, 8'hB5, 8'hB6, 8'hB7};

  // Test 4 expectations: out_ready stall on cycles 2..4, then a re-grant.
  logic       t4Ar  [10] = '{0, 1, 0, 0, 0, 1, 1, 1, 1, 1};
  logic [7:0] t4Out [10] = '{8'h00, 8'h00, 8'h50, 8'h50, 8'h50, 8'h50,
                             8'h51, 8'h52, 8'h53, 8'h54};

  // Test 5 expectations: A quits after two beats, B gets a full burst.
  logic       t5Av  [10] = '{1, 1, 1, 0, 0, 1, 1, 1, 1, 1};
  logic       t5Bv  [10] = '{0, 1, 1, 1, 1, 1, 1, 1, 1, 1};
  logic       t5Sel [10] = '{0, 1, 1, 1, 0, 0, 0, 0, 1, 1};
  logic       t5Ov  [10] = '{0, 0, 1, 1, 0, 1, 1, 1, 1, 1};
  logic [7:0] t5Out [10] = '{8'h00, 8'h00, 8'h60, 8'h61, 8'h00, 8'h70,
                             8'h71, 8'h72, 8'h73, 8'h62};

  tcon_arbiter #(
    .DATA_W   (8),
    .MAX_BURST(4)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .a_valid  (a_valid),
    .a_data   (a_data),
    .a_ready  (a_ready),
    .b_valid  (b_valid),
    .b_data   (b_data),
    .b_ready  (b_ready),
    .out_valid(out_valid),
    .out_data (out_data),
    .out_ready(out_ready),
    .sel      (sel),
    .busy     (busy)
  );

  // Free-running clock, 10 time-unit period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic compare(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive handshake inputs; each requester's data tracks its own beat index.
  task automatic applyStimulus(input logic aV, input logic bV, input logic oR);
    a_valid   = aV;
    b_valid   = bV;
    out_ready = oR;
    a_data    = aBase + aIdx;
    b_data    = bBase + bIdx;
    #1;
  endtask

  // Compare every output for this cycle, then advance one clock, stepping a
  // requester's beat index whenever it handed a beat over.
  task automatic checkOutput(input string tag, input logic eSel, input logic eBusy,
                             input logic eAr, input logic eBr, input logic eOv,
                             input logic [7:0] eOd, input logic chkData);
    logic aFire;
    logic bFire;
    compare({tag, ".sel"}, {7'd0, sel}, {7'd0, eSel});
    compare({tag, ".busy"}, {7'd0, busy}, {7'd0, eBusy});
    compare({tag, ".a_ready"}, {7'd0, a_ready}, {7'd0, eAr});
    compare({tag, ".b_ready"}, {7'd0, b_ready}, {7'd0, eBr});
    compare({tag, ".out_valid"}, {7'd0, out_valid}, {7'd0, eOv});
    if (chkData) compare({tag, ".out_data"}, out_data, eOd);
    aFire = a_valid & a_ready;
    bFire = b_valid & b_ready;
    @(negedge clk);
    if (aFire) aIdx++;
    if (bFire) bIdx++;
  endtask

  initial begin
    // Test 1: reset held with both requesters active.
    rst_n = 1'b0;
    applyStimulus(1, 1, 1);
    @(negedge clk);
    checkOutput("t1_rst0", 0, 0, 0, 0, 0, 8'h00, 1);
    applyStimulus(1, 1, 1);
    checkOutput("t1_rst1", 0, 0, 0, 0, 0, 8'h00, 1);
    rst_n = 1'b1;
    applyStimulus(0, 0, 1);
    checkOutput("t1_idle", 0, 0, 0, 0, 0, 8'h00, 1);

    // Test 2: single A beat, IDLE -> grant -> output latency.
    aBase = 8'hA5; aIdx = 0;
    applyStimulus(1, 0, 1);
    checkOutput("t2_c0", 0, 0, 0, 0, 0, 8'h00, 0);
    applyStimulus(1, 0, 1);
    checkOutput("t2_c1", 1, 1, 1, 0, 0, 8'h00, 0);
    applyStimulus(0, 0, 1);
    checkOutput("t2_c2", 1, 1, 1, 0, 1, 8'hA5, 1);
    applyStimulus(0, 0, 1);
    checkOutput("t2_c3", 0, 0, 0, 0, 0, 8'h00, 0);

    // Test 3: both streaming; pointer now favours B, so B bursts first.
    aBase = 8'hA0; bBase = 8'hB0; aIdx = 0; bIdx = 0;
    for (int k = 0; k < 14; k++) begin
      applyStimulus(1, 1, 1);
      checkOutput($sformatf("t3_c%0d", k), t3Sel[k], k != 0,
                  t3Sel[k] && k != 0, !t3Sel[k] && k != 0, k >= 2,
                  (k >= 2) ? t3Out[k-2] : 8'h00, k >= 2);
    end
    applyStimulus(0, 0, 1);
    checkOutput("t3_drain", 1, 1, 1, 0, 1, 8'hA4, 1);
    applyStimulus(0, 0, 1);
    checkOutput("t3_idle", 0, 0, 0, 0, 0, 8'h00, 0);

    // Test 4: A alone with a three-cycle downstream stall, then burst re-grant.
    aBase = 8'h50; aIdx = 0;
    for (int k = 0; k < 10; k++) begin
      applyStimulus(1, 0, !(k >= 2 && k <= 4));
      checkOutput($sformatf("t4_c%0d", k), k != 0, k != 0, t4Ar[k], 0,
                  k >= 2, t4Out[k], k >= 2);
    end
    applyStimulus(0, 0, 1);
    checkOutput("t4_drain", 1, 1, 1, 0, 1, 8'h55, 1);
    applyStimulus(0, 0, 1);
    checkOutput("t4_idle", 0, 0, 0, 0, 0, 8'h00, 0);

    // Test 5: A drops after two beats while B waits.
    aBase = 8'h60; bBase = 8'h70; aIdx = 0; bIdx = 0;
    for (int k = 0; k < 10; k++) begin
      applyStimulus(t5Av[k], t5Bv[k], 1);
      checkOutput($sformatf("t5_c%0d", k), t5Sel[k], k != 0,
                  t5Sel[k], !t5Sel[k] && k != 0, t5Ov[k], t5Out[k], t5Ov[k]);
    end
    applyStimulus(0, 0, 1);
    checkOutput("t5_drain", 1, 1, 1, 0, 1, 8'h63, 1);
    applyStimulus(0, 0, 1);
    checkOutput("t5_idle", 0, 0, 0, 0, 0, 8'h00, 0);

    // Test 6: reset in the middle of an A burst, then both request.
    aBase = 8'h80; aIdx = 0;
    applyStimulus(1, 0, 1);
    checkOutput("t6_c0", 0, 0, 0, 0, 0, 8'h00, 0);
    applyStimulus(1, 0, 1);
    checkOutput("t6_c1", 1, 1, 1, 0, 0, 8'h00, 0);
    applyStimulus(1, 1, 1);
    checkOutput("t6_c2", 1, 1, 1, 0, 1, 8'h80, 1);
    rst_n = 1'b0;
    applyStimulus(1, 1, 1);
    checkOutput("t6_c3", 1, 1, 1, 0, 1, 8'h81, 1);
    rst_n = 1'b1;
    applyStimulus(1, 1, 1);
    checkOutput("t6_rst", 0, 0, 0, 0, 0, 8'h00, 1);
    applyStimulus(1, 1, 1);
    checkOutput("t6_regrant", 1, 1, 1, 0, 0, 8'h00, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
